// File: rtl/uart_cmd_dispatcher.sv
// uart_cmd_dispatcher: buffers UART command bytes in a FIFO and dispatches them to read/write arbiters
module uart_cmd_dispatcher #(
    parameter int CMD_W      = 3,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8,
    // IDCODE instruction address, used as the write-channel address of a reset broadcast
    parameter logic [ADDR_W-1:0] RESET_WR_ADDR = ADDR_W'(2)
) (
    input  logic              CLK_I,
    input  logic              RST_NI,
    input  logic              READ_I,
    input  logic              CMD_REC_I,
    input  logic [7:0]        DATA_REC_I,
    input  logic              ERR_CLR_I,
    output logic              BUSY_O,
    output logic              FULL_O,
    output logic              OVERFLOW_O,
    output logic [CNT_W-1:0]  DROP_CNT_O,
    output logic [CMD_W-1:0]  READ_COMMAND_O,
    output logic [ADDR_W-1:0] READ_ADDRESS_O,
    output logic              READ_ARBITER_VALID_O,
    input  logic              READ_ARBITER_READY_I,
    output logic [CMD_W-1:0]  WRITE_COMMAND_O,
    output logic [ADDR_W-1:0] WRITE_ADDRESS_O,
    output logic              WRITE_ARBITER_VALID_O,
    input  logic              WRITE_ARBITER_READY_I
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CMD_W-1:0] CMD_NOP       = CMD_W'(0);
    localparam logic [CMD_W-1:0] CMD_READ      = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_CONT_READ = CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_WRITE     = CMD_W'(3);
    localparam logic [CMD_W-1:0] CMD_RESET     = CMD_W'(4);

    if (CMD_W + ADDR_W != 8) begin : g_bad_width
        $error("CMD_W + ADDR_W must equal 8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end

    typedef enum logic {IDLE, DISPATCH} state_t;
    state_t state, state_nxt;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic [7:0]        head;
    logic [CMD_W-1:0]  head_cmd;
    logic [ADDR_W-1:0] head_addr;
    logic              capture, push, pop, empty, head_rd, head_wr, done_now, drop;
    logic              rd_valid_nxt, wr_valid_nxt;
    logic [CMD_W-1:0]  rd_cmd_nxt, wr_cmd_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt, wr_addr_nxt;

    assign capture   = READ_I && CMD_REC_I;
    assign push      = capture && !FULL_O;
    assign empty     = count == '0;
    assign FULL_O    = count == (PTR_W+1)'(FIFO_DEPTH);
    assign head      = fifo_mem[rd_ptr];
    assign head_cmd  = head[7:ADDR_W];
    assign head_addr = head[ADDR_W-1:0];
    assign head_rd   = head_cmd == CMD_READ || head_cmd == CMD_CONT_READ || head_cmd == CMD_RESET;
    assign head_wr   = head_cmd == CMD_WRITE || head_cmd == CMD_RESET;
    // A channel counts as done once its valid is low or is being accepted this cycle
    assign done_now  = (!READ_ARBITER_VALID_O || READ_ARBITER_READY_I) &&
                       (!WRITE_ARBITER_VALID_O || WRITE_ARBITER_READY_I);
    assign pop       = !empty && (state == IDLE || done_now);
    assign drop      = pop && !head_rd && !head_wr;
    assign BUSY_O    = !empty || state == DISPATCH;

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge CLK_I) begin
        if (push) fifo_mem[wr_ptr] <= DATA_REC_I;
    end

    // FIFO pointers, occupancy and error status
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            OVERFLOW_O <= 1'b0;
            DROP_CNT_O <= '0;
        end else begin
            wr_ptr     <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count      <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            OVERFLOW_O <= ERR_CLR_I ? 1'b0 : OVERFLOW_O || (capture && FULL_O);
            DROP_CNT_O <= ERR_CLR_I ? '0 : (drop && DROP_CNT_O != '1) ? DROP_CNT_O + 1'b1 : DROP_CNT_O;
        end
    end

    // Dispatcher state register
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next state: a pop loads a new command; otherwise leave DISPATCH once both channels are done
    always_comb begin
        state_nxt = pop ? ((head_rd || head_wr) ? DISPATCH : IDLE) : (done_now ? IDLE : state);
    end

    // Channel payload/valid next values; payload only changes when a new command is loaded
    always_comb begin
        rd_valid_nxt = pop ? head_rd : READ_ARBITER_VALID_O && !READ_ARBITER_READY_I;
        wr_valid_nxt = pop ? head_wr : WRITE_ARBITER_VALID_O && !WRITE_ARBITER_READY_I;
        rd_cmd_nxt   = (pop && head_rd) ? head_cmd : READ_COMMAND_O;
        rd_addr_nxt  = (pop && head_rd) ? head_addr : READ_ADDRESS_O;
        wr_cmd_nxt   = (pop && head_wr) ? head_cmd : WRITE_COMMAND_O;
        wr_addr_nxt  = (pop && head_wr) ? ((head_cmd == CMD_RESET) ? RESET_WR_ADDR : head_addr) : WRITE_ADDRESS_O;
    end

    // Registered channel outputs
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            READ_ARBITER_VALID_O  <= 1'b0;
            WRITE_ARBITER_VALID_O <= 1'b0;
            READ_COMMAND_O        <= CMD_NOP;
            READ_ADDRESS_O        <= '0;
            WRITE_COMMAND_O       <= CMD_NOP;
            WRITE_ADDRESS_O       <= '0;
        end else begin
            READ_ARBITER_VALID_O  <= rd_valid_nxt;
            WRITE_ARBITER_VALID_O <= wr_valid_nxt;
            READ_COMMAND_O        <= rd_cmd_nxt;
            READ_ADDRESS_O        <= rd_addr_nxt;
            WRITE_COMMAND_O       <= wr_cmd_nxt;
            WRITE_ADDRESS_O       <= wr_addr_nxt;
        end
    end
endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// tb_uart_cmd_dispatcher: scoreboard bench for the UART command dispatcher
module tb_uart_cmd_dispatcher;
    localparam logic [2:0] CMD_NOP = 3'd0, CMD_READ = 3'd1, CMD_CONT_READ = 3'd2, CMD_WRITE = 3'd3, CMD_RESET = 3'd4;
    localparam logic [4:0] RST_WR_ADDR = 5'h02;

    logic       CLK_I = 0, RST_NI = 0, READ_I = 0, CMD_REC_I = 0, ERR_CLR_I = 0;
    logic [7:0] DATA_REC_I = 0;
    logic       READ_ARBITER_READY_I = 0, WRITE_ARBITER_READY_I = 0;
    logic       BUSY_O, FULL_O, OVERFLOW_O, READ_ARBITER_VALID_O, WRITE_ARBITER_VALID_O;
    logic [7:0] DROP_CNT_O;
    logic [2:0] READ_COMMAND_O, WRITE_COMMAND_O;
    logic [4:0] READ_ADDRESS_O, WRITE_ADDRESS_O;

    uart_cmd_dispatcher dut (
        .CLK_I(CLK_I), .RST_NI(RST_NI), .READ_I(READ_I), .CMD_REC_I(CMD_REC_I),
        .DATA_REC_I(DATA_REC_I), .ERR_CLR_I(ERR_CLR_I), .BUSY_O(BUSY_O), .FULL_O(FULL_O),
        .OVERFLOW_O(OVERFLOW_O), .DROP_CNT_O(DROP_CNT_O),
        .READ_COMMAND_O(READ_COMMAND_O), .READ_ADDRESS_O(READ_ADDRESS_O),
        .READ_ARBITER_VALID_O(READ_ARBITER_VALID_O), .READ_ARBITER_READY_I(READ_ARBITER_READY_I),
        .WRITE_COMMAND_O(WRITE_COMMAND_O), .WRITE_ADDRESS_O(WRITE_ADDRESS_O),
        .WRITE_ARBITER_VALID_O(WRITE_ARBITER_VALID_O), .WRITE_ARBITER_READY_I(WRITE_ARBITER_READY_I)
    );

    always #5 CLK_I = ~CLK_I;

    int         tests = 0, fails = 0;
    logic [7:0] exp_rd[$], exp_wr[$], e_rd, e_wr;
    int         xfer_ch[$];

    // Scoreboard: a handshake seen mid-cycle completes on the next rising edge
    always @(negedge CLK_I) begin
        if (RST_NI && READ_ARBITER_VALID_O && READ_ARBITER_READY_I) begin
            tests++;
            xfer_ch.push_back(0);
            if (exp_rd.size() == 0) begin
                fails++; $display("FAIL rd_unexpected got=%h exp=none", {READ_COMMAND_O, READ_ADDRESS_O});
            end else begin
                e_rd = exp_rd.pop_front();
                if ({READ_COMMAND_O, READ_ADDRESS_O} !== e_rd) begin
                    fails++; $display("FAIL rd_xfer got=%h exp=%h", {READ_COMMAND_O, READ_ADDRESS_O}, e_rd);
                end
            end
        end
        if (RST_NI && WRITE_ARBITER_VALID_O && WRITE_ARBITER_READY_I) begin
            tests++;
            xfer_ch.push_back(1);
            if (exp_wr.size() == 0) begin
                fails++; $display("FAIL wr_unexpected got=%h exp=none", {WRITE_COMMAND_O, WRITE_ADDRESS_O});
            end else begin
                e_wr = exp_wr.pop_front();
                if ({WRITE_COMMAND_O, WRITE_ADDRESS_O} !== e_wr) begin
                    fails++; $display("FAIL wr_xfer got=%h exp=%h", {WRITE_COMMAND_O, WRITE_ADDRESS_O}, e_wr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK_I); #1;
    endtask

    task automatic capture(input logic [7:0] b);
        READ_I = 1; CMD_REC_I = 1; DATA_REC_I = b;
        tick();
        READ_I = 0; CMD_REC_I = 0;
    endtask

    task automatic test_reset();
        #1;
        tests++; if ({READ_ARBITER_VALID_O, WRITE_ARBITER_VALID_O, BUSY_O, FULL_O, OVERFLOW_O} !== 5'b0) begin fails++; $display("FAIL reset_flags got=%b exp=00000", {READ_ARBITER_VALID_O, WRITE_ARBITER_VALID_O, BUSY_O, FULL_O, OVERFLOW_O}); end
        tests++; if (DROP_CNT_O !== 8'd0) begin fails++; $display("FAIL reset_drop got=%0d exp=0", DROP_CNT_O); end
        tests++; if ({READ_COMMAND_O, READ_ADDRESS_O, WRITE_COMMAND_O, WRITE_ADDRESS_O} !== {CMD_NOP, 5'd0, CMD_NOP, 5'd0}) begin fails++; $display("FAIL reset_payload got=%h exp=%h", {READ_COMMAND_O, READ_ADDRESS_O, WRITE_COMMAND_O, WRITE_ADDRESS_O}, {CMD_NOP, 5'd0, CMD_NOP, 5'd0}); end
        tick(); tick();
        RST_NI = 1;
        tick();
        tests++; if (BUSY_O !== 1'b0) begin fails++; $display("FAIL reset_release_busy got=%b exp=0", BUSY_O); end
    endtask

    task automatic test_single_read();
        READ_ARBITER_READY_I = 1; WRITE_ARBITER_READY_I = 1;
        exp_rd.push_back({CMD_READ, 5'h11});
        capture({CMD_READ, 5'h11});
        tests++; if (READ_ARBITER_VALID_O !== 1'b0) begin fails++; $display("FAIL single_early_valid got=%b exp=0", READ_ARBITER_VALID_O); end
        tick();
        tests++; if ({READ_ARBITER_VALID_O, READ_COMMAND_O, READ_ADDRESS_O} !== {1'b1, CMD_READ, 5'h11}) begin fails++; $display("FAIL single_valid got=%h exp=%h", {READ_ARBITER_VALID_O, READ_COMMAND_O, READ_ADDRESS_O}, {1'b1, CMD_READ, 5'h11}); end
        tests++; if (WRITE_ARBITER_VALID_O !== 1'b0) begin fails++; $display("FAIL single_wr_touched got=%b exp=0", WRITE_ARBITER_VALID_O); end
        tick();
        tests++; if ({READ_ARBITER_VALID_O, BUSY_O} !== 2'b00) begin fails++; $display("FAIL single_after got=%b exp=00", {READ_ARBITER_VALID_O, BUSY_O}); end
        tests++; if (WRITE_COMMAND_O !== CMD_NOP) begin fails++; $display("FAIL single_wr_cmd got=%0d exp=%0d", WRITE_COMMAND_O, CMD_NOP); end
        tests++; if (exp_rd.size() != 0) begin fails++; $display("FAIL single_missing got=%0d exp=0", exp_rd.size()); end
    endtask

    task automatic test_backpressure();
        WRITE_ARBITER_READY_I = 0;
        exp_wr.push_back({CMD_WRITE, 5'h10});
        capture({CMD_WRITE, 5'h10});
        tick();
        for (int i = 0; i < 5; i++) begin
            tests++; if ({WRITE_ARBITER_VALID_O, WRITE_ADDRESS_O} !== {1'b1, 5'h10}) begin fails++; $display("FAIL bp_hold%0d got=%h exp=%h", i, {WRITE_ARBITER_VALID_O, WRITE_ADDRESS_O}, {1'b1, 5'h10}); end
            tick();
        end
        tests++; if ({WRITE_ARBITER_VALID_O, WRITE_ADDRESS_O} !== {1'b1, 5'h10}) begin fails++; $display("FAIL bp_last got=%h exp=%h", {WRITE_ARBITER_VALID_O, WRITE_ADDRESS_O}, {1'b1, 5'h10}); end
        WRITE_ARBITER_READY_I = 1;
        tick();
        tests++; if (WRITE_ARBITER_VALID_O !== 1'b0) begin fails++; $display("FAIL bp_drop got=%b exp=0", WRITE_ARBITER_VALID_O); end
        tests++; if (exp_wr.size() != 0) begin fails++; $display("FAIL bp_missing got=%0d exp=0", exp_wr.size()); end
    endtask

    task automatic test_reset_broadcast();
        READ_ARBITER_READY_I = 0; WRITE_ARBITER_READY_I = 0;
        exp_rd.push_back({CMD_RESET, 5'h01}); exp_rd.push_back({CMD_READ, 5'h07});
        exp_wr.push_back({CMD_RESET, RST_WR_ADDR});
        capture({CMD_RESET, 5'h01});
        capture({CMD_READ, 5'h07});
        tests++; if ({READ_ARBITER_VALID_O, WRITE_ARBITER_VALID_O, WRITE_COMMAND_O, WRITE_ADDRESS_O, READ_ADDRESS_O} !== {2'b11, CMD_RESET, RST_WR_ADDR, 5'h01}) begin fails++; $display("FAIL bc_start got=%h exp=%h", {READ_ARBITER_VALID_O, WRITE_ARBITER_VALID_O, WRITE_COMMAND_O, WRITE_ADDRESS_O, READ_ADDRESS_O}, {2'b11, CMD_RESET, RST_WR_ADDR, 5'h01}); end
        tick();
        READ_ARBITER_READY_I = 1;
        tick();
        READ_ARBITER_READY_I = 0;
        tests++; if ({READ_ARBITER_VALID_O, WRITE_ARBITER_VALID_O} !== 2'b01) begin fails++; $display("FAIL bc_cycle3 got=%b exp=01", {READ_ARBITER_VALID_O, WRITE_ARBITER_VALID_O}); end
        tick();
        tests++; if ({READ_ARBITER_VALID_O, WRITE_ARBITER_VALID_O} !== 2'b01) begin fails++; $display("FAIL bc_cycle4 got=%b exp=01", {READ_ARBITER_VALID_O, WRITE_ARBITER_VALID_O}); end
        WRITE_ARBITER_READY_I = 1;
        tick();
        tests++; if ({READ_ARBITER_VALID_O, WRITE_ARBITER_VALID_O, READ_COMMAND_O, READ_ADDRESS_O} !== {2'b10, CMD_READ, 5'h07}) begin fails++; $display("FAIL bc_next got=%h exp=%h", {READ_ARBITER_VALID_O, WRITE_ARBITER_VALID_O, READ_COMMAND_O, READ_ADDRESS_O}, {2'b10, CMD_READ, 5'h07}); end
        READ_ARBITER_READY_I = 1;
        tick();
        tests++; if (exp_rd.size() + exp_wr.size() != 0) begin fails++; $display("FAIL bc_missing got=%0d exp=0", exp_rd.size() + exp_wr.size()); end
    endtask

    task automatic test_overflow();
        int n;
        READ_ARBITER_READY_I = 0; WRITE_ARBITER_READY_I = 0;
        // One entry moves straight into the dispatch registers, so depth+2 bytes are needed to overflow
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_wr.push_back({CMD_WRITE, 5'(i)});
            capture({CMD_WRITE, 5'(i)});
        end
        tests++; if ({FULL_O, OVERFLOW_O, BUSY_O} !== 3'b111) begin fails++; $display("FAIL ovf_flags got=%b exp=111", {FULL_O, OVERFLOW_O, BUSY_O}); end
        WRITE_ARBITER_READY_I = 1;
        n = 0;
        while (exp_wr.size() != 0 && n < 40) begin tick(); n++; end
        tests++; if (exp_wr.size() != 0) begin fails++; $display("FAIL ovf_timeout got=%0d exp=0", exp_wr.size()); end
        tick(); tick();
        tests++; if ({FULL_O, BUSY_O, OVERFLOW_O} !== 3'b001) begin fails++; $display("FAIL ovf_after got=%b exp=001", {FULL_O, BUSY_O, OVERFLOW_O}); end
        ERR_CLR_I = 1; tick(); ERR_CLR_I = 0;
        tests++; if (OVERFLOW_O !== 1'b0) begin fails++; $display("FAIL ovf_clear got=%b exp=0", OVERFLOW_O); end
    endtask

    task automatic test_drops_b2b();
        READ_ARBITER_READY_I = 1; WRITE_ARBITER_READY_I = 1;
        xfer_ch.delete();
        exp_rd.push_back({CMD_READ, 5'h03});
        exp_wr.push_back({CMD_WRITE, 5'h09});
        capture({CMD_READ, 5'h03});
        capture({CMD_NOP, 5'h04});
        capture({3'd6, 5'h15});
        capture({CMD_WRITE, 5'h09});
        for (int i = 0; i < 6; i++) tick();
        tests++; if (DROP_CNT_O !== 8'd2) begin fails++; $display("FAIL drop_count got=%0d exp=2", DROP_CNT_O); end
        tests++; if (xfer_ch.size() != 2 || xfer_ch[0] != 0 || xfer_ch[1] != 1) begin fails++; $display("FAIL drop_order got=%0d transfers exp=2 (rd then wr)", xfer_ch.size()); end
        tests++; if (exp_rd.size() + exp_wr.size() != 0) begin fails++; $display("FAIL drop_missing got=%0d exp=0", exp_rd.size() + exp_wr.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) begin
            b[i] = {(i % 2 == 0) ? CMD_READ : CMD_CONT_READ, 5'(i + 8)};
            exp_rd.push_back(b[i]);
        end
        READ_I = 1; CMD_REC_I = 1;
        for (int i = 0; i < 4; i++) begin
            DATA_REC_I = b[i];
            tick();
            if (i > 0) begin
                tests++; if ({READ_ARBITER_VALID_O, READ_COMMAND_O, READ_ADDRESS_O} !== {1'b1, b[i-1]}) begin fails++; $display("FAIL b2b_%0d got=%h exp=%h", i - 1, {READ_ARBITER_VALID_O, READ_COMMAND_O, READ_ADDRESS_O}, {1'b1, b[i-1]}); end
            end
        end
        READ_I = 0; CMD_REC_I = 0;
        tick();
        tests++; if ({READ_ARBITER_VALID_O, READ_COMMAND_O, READ_ADDRESS_O} !== {1'b1, b[3]}) begin fails++; $display("FAIL b2b_3 got=%h exp=%h", {READ_ARBITER_VALID_O, READ_COMMAND_O, READ_ADDRESS_O}, {1'b1, b[3]}); end
        tick();
        tests++; if ({READ_ARBITER_VALID_O, BUSY_O} !== 2'b00) begin fails++; $display("FAIL b2b_end got=%b exp=00", {READ_ARBITER_VALID_O, BUSY_O}); end
    endtask

    task automatic test_saturation();
        ERR_CLR_I = 1; tick(); ERR_CLR_I = 0;
        tests++; if (DROP_CNT_O !== 8'd0) begin fails++; $display("FAIL sat_clear got=%0d exp=0", DROP_CNT_O); end
        READ_I = 1; CMD_REC_I = 1; DATA_REC_I = {CMD_NOP, 5'h00};
        for (int i = 0; i < 300; i++) tick();
        READ_I = 0; CMD_REC_I = 0;
        for (int i = 0; i < 4; i++) tick();
        tests++; if (DROP_CNT_O !== 8'd255) begin fails++; $display("FAIL sat_count got=%0d exp=255", DROP_CNT_O); end
        tests++; if (OVERFLOW_O !== 1'b0) begin fails++; $display("FAIL sat_overflow got=%b exp=0", OVERFLOW_O); end
    endtask

    task automatic test_async_reset();
        READ_ARBITER_READY_I = 0; WRITE_ARBITER_READY_I = 0;
        capture({CMD_RESET, 5'h05});
        capture({CMD_WRITE, 5'h06});
        tests++; if ({READ_ARBITER_VALID_O, WRITE_ARBITER_VALID_O} !== 2'b11) begin fails++; $display("FAIL arst_pre got=%b exp=11", {READ_ARBITER_VALID_O, WRITE_ARBITER_VALID_O}); end
        #3 RST_NI = 0;
        #1;
        tests++; if ({READ_ARBITER_VALID_O, WRITE_ARBITER_VALID_O, BUSY_O, READ_COMMAND_O} !== {3'b000, CMD_NOP}) begin fails++; $display("FAIL arst_immediate got=%h exp=%h", {READ_ARBITER_VALID_O, WRITE_ARBITER_VALID_O, BUSY_O, READ_COMMAND_O}, {3'b000, CMD_NOP}); end
        tick();
        RST_NI = 1;
        READ_ARBITER_READY_I = 1; WRITE_ARBITER_READY_I = 1;
        tick(); tick();
        tests++; if ({READ_ARBITER_VALID_O, WRITE_ARBITER_VALID_O, BUSY_O, FULL_O, WRITE_ADDRESS_O} !== 9'd0) begin fails++; $display("FAIL arst_after got=%h exp=0", {READ_ARBITER_VALID_O, WRITE_ARBITER_VALID_O, BUSY_O, FULL_O, WRITE_ADDRESS_O}); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_backpressure();
        test_reset_broadcast();
        test_overflow();
        test_drops_b2b();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        tests++; if (exp_rd.size() + exp_wr.size() != 0) begin fails++; $display("FAIL final_pending got=%0d exp=0", exp_rd.size() + exp_wr.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
